vocab_scan_ctrl: RTL and testbench

VOCAB_SCAN_CTRL -- requirements
Module: vocab_scan_ctrl

---
 rtl/vocab_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_vocab_scan_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vocab_scan_ctrl.sv
// Sequential vocabulary scanner: walks fixed-length entries in an external SRAM,
// comparing one character per read until a match, a null entry or the range limit.
module vocab_scan_ctrl #(
   parameter int ADDR_WIDTH  = 4,
   parameter int WORD_LENGTH = 3,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
   input  logic [ADDR_WIDTH-1:0]             start_addr,
   input  logic [ADDR_WIDTH-1:0]             end_addr,
   output logic                              mem_cs,
   output logic                              mem_we,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   input  logic [DATA_WIDTH-1:0]             mem_dout,
   output logic                              busy,
   output logic                              done,
   output logic                              found,
   output logic [ADDR_WIDTH-1:0]             match_addr,
   output logic                              null_hit,
   output logic                              exhausted
);

   localparam int EW    = ADDR_WIDTH + 1;
   localparam int IDX_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
   localparam logic [EW-1:0]    WL_E     = EW'(WORD_LENGTH);
   localparam logic [EW-1:0]    WL_M1    = EW'(WORD_LENGTH - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_LENGTH - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, COMPARE, DONE} state_t;

   state_t                            state_q;
   logic [WORD_LENGTH*DATA_WIDTH-1:0] word_q;
   logic [ADDR_WIDTH-1:0]             end_q;
   logic [ADDR_WIDTH-1:0]             base_q;
   logic [IDX_W-1:0]                  idx_q;
   logic [ADDR_WIDTH-1:0]             mem_addr_q;
   logic                              mem_cs_q;
   logic                              busy_q;
   logic                              done_q;
   logic                              found_q;
   logic                              null_hit_q;
   logic                              exhausted_q;
   logic [ADDR_WIDTH-1:0]             match_addr_q;

   logic [EW-1:0]         first_last_d;
   logic [EW-1:0]         nb_d;
   logic [EW-1:0]         nb_last_d;
   logic [DATA_WIDTH-1:0] key_chr_d;

   // Range checks are one bit wider than the address so an entry running off the top never wraps.
   always_comb begin
      first_last_d = {1'b0, start_addr} + WL_M1;
      nb_d         = {1'b0, base_q} + WL_E;
      nb_last_d    = nb_d + WL_M1;
      key_chr_d    = '0;
      for (int i = 0; i < WORD_LENGTH; i++) begin
         if (idx_q == IDX_W'(i)) key_chr_d = word_q[(WORD_LENGTH-1-i)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         base_q       <= '0;
         idx_q        <= '0;
         mem_addr_q   <= '0;
         mem_cs_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         found_q      <= 1'b0;
         null_hit_q   <= 1'b0;
         exhausted_q  <= 1'b0;
         match_addr_q <= '0;
      end else begin
         done_q   <= 1'b0;
         mem_cs_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  word_q       <= word;
                  end_q        <= end_addr;
                  base_q       <= start_addr;
                  idx_q        <= '0;
                  found_q      <= 1'b0;
                  null_hit_q   <= 1'b0;
                  match_addr_q <= '0;
                  busy_q       <= 1'b1;
                  if (first_last_d > {1'b0, end_addr}) begin
                     exhausted_q <= 1'b1;
                     done_q      <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     exhausted_q <= 1'b0;
                     mem_cs_q    <= 1'b1;
                     mem_addr_q  <= start_addr;
                     state_q     <= ISSUE;
                  end
               end
            end
            ISSUE: state_q <= COMPARE;
            COMPARE: begin
               if (idx_q == '0 && mem_dout == '0) begin
                  null_hit_q <= 1'b1;
                  done_q     <= 1'b1;
                  state_q    <= DONE;
               end else if (mem_dout == key_chr_d) begin
                  if (idx_q == IDX_LAST) begin
                     found_q      <= 1'b1;
                     match_addr_q <= base_q;
                     done_q       <= 1'b1;
                     state_q      <= DONE;
                  end else begin
                     idx_q      <= idx_q + 1'b1;
                     mem_addr_q <= mem_addr_q + 1'b1;
                     mem_cs_q   <= 1'b1;
                     state_q    <= ISSUE;
                  end
               end else if (nb_last_d > {1'b0, end_q}) begin
                  exhausted_q <= 1'b1;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  base_q     <= nb_d[ADDR_WIDTH-1:0];
                  idx_q      <= '0;
                  mem_addr_q <= nb_d[ADDR_WIDTH-1:0];
                  mem_cs_q   <= 1'b1;
                  state_q    <= ISSUE;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_cs     = mem_cs_q;
   assign mem_we     = 1'b0;
   assign mem_addr   = mem_addr_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign found      = found_q;
   assign null_hit   = null_hit_q;
   assign exhausted  = exhausted_q;
   assign match_addr = match_addr_q;

endmodule

// File: tb/tb_vocab_scan_ctrl.sv
// Scoreboard bench for vocab_scan_ctrl: a driver pushes model results per scan,
// a negedge monitor pops and compares them whenever done pulses.
module tb_vocab_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [23:0] word = '0;
   logic [3:0]  start_addr = '0;
   logic [3:0]  end_addr = '0;
   logic        mem_cs, mem_we;
   logic [3:0]  mem_addr;
   logic [7:0]  mem_dout = '0;
   logic        busy, done, found, null_hit, exhausted;
   logic [3:0]  match_addr;

   vocab_scan_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .word(word),
      .start_addr(start_addr), .end_addr(end_addr),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .busy(busy), .done(done), .found(found), .match_addr(match_addr),
      .null_hit(null_hit), .exhausted(exhausted)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [16];
   always @(posedge clk) if (mem_cs) mem_dout <= mem[mem_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int found; int nul; int exh; int maddr; int lat; int reads; int s; int e; int t0;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   passed = 0;
   int   reads = 0;
   int   oor = 0;

   task automatic chk(input string name, input int act, input int expv);
      total++;
      if (act == expv) passed++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
   endtask

   // Reference: walk entries of three characters from s while the whole entry fits below e.
   function automatic exp_t model(input logic [23:0] k, input int s, input int e);
      exp_t r;
      int   b, n;
      bit   fin;
      logic [7:0] c;
      r = '{default: 0};
      r.s = s; r.e = e;
      n = 0;
      if (s + 2 > e) r.exh = 1;
      else begin
         b = s; fin = 0;
         while (!fin) begin
            for (int i = 0; i < 3; i++) begin
               n++;
               c = mem[b + i];
               if (i == 0 && c == 8'h00) begin r.nul = 1; fin = 1; break; end
               if (c != k[23 - 8*i -: 8]) break;
               if (i == 2) begin r.found = 1; r.maddr = b; fin = 1; end
            end
            if (!fin) begin
               if (b + 5 > e) begin r.exh = 1; fin = 1; end
               else b += 3;
            end
         end
      end
      r.lat = 2*n + 1;
      r.reads = n;
      return r;
   endfunction

   always @(negedge clk) begin
      exp_t x;
      if (!rst_n) begin
         reads = 0; oor = 0;
      end else begin
         if (mem_cs) begin
            reads++;
            if (sb.size() > 0 && (int'(mem_addr) < sb[0].s || int'(mem_addr) > sb[0].e)) oor++;
         end
         if (done) begin
            if (sb.size() == 0) chk("spurious_done", 1, 0);
            else begin
               x = sb.pop_front();
               chk("found", int'(found), x.found);
               chk("null_hit", int'(null_hit), x.nul);
               chk("exhausted", int'(exhausted), x.exh);
               chk("match_addr", int'(match_addr), x.maddr);
               chk("latency", cyc - x.t0, x.lat);
               chk("reads", reads, x.reads);
               chk("out_of_range_reads", oor, 0);
               chk("busy_at_done", int'(busy), 1);
               chk("mem_we", int'(mem_we), 0);
            end
            reads = 0; oor = 0;
         end
      end
   end

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         chk("scan_timeout", 1, 0);
         sb.delete();
      end
   endtask

   task automatic run_scan(input logic [23:0] k, input int s, input int e, input bit hold);
      exp_t x;
      @(negedge clk); #1;
      word = k; start_addr = 4'(s); end_addr = 4'(e); start = 1'b1;
      x = model(k, s, e);
      x.t0 = cyc;
      sb.push_back(x);
      if (!hold) begin
         @(negedge clk); #1;
         start = 1'b0;
      end
      wait_drain();
      start = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_found"}, int'(found), 0);
      chk({tag, "_null_hit"}, int'(null_hit), 0);
      chk({tag, "_exhausted"}, int'(exhausted), 0);
      chk({tag, "_mem_cs"}, int'(mem_cs), 0);
      chk({tag, "_match_addr"}, int'(match_addr), 0);
   endtask

   task automatic load_default_mem();
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[0] = 8'h63; mem[1] = 8'h61; mem[2] = 8'h74;
      mem[3] = 8'h64; mem[4] = 8'h6F; mem[5] = 8'h67;
      mem[13] = 8'h78; mem[14] = 8'h79; mem[15] = 8'h71;
   endtask

   initial begin
      int r;
      logic [23:0] k;
      int s, e, b;
      load_default_mem();
      start = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_all_zero("reset");
      start = 1'b0;
      rst_n = 1'b1;

      run_scan("dog", 0, 15, 1'b0);
      run_scan("cow", 0, 15, 1'b0);
      run_scan("cat", 0, 1, 1'b0);
      run_scan("cat", 3, 5, 1'b0);
      run_scan("xyz", 13, 15, 1'b0);
      run_scan("cat", 0, 15, 1'b0);

      // start stays high across the whole scan; a single done must result
      run_scan("dog", 0, 15, 1'b1);
      @(negedge clk); #1;
      chk("hold_done_low", int'(done), 0);
      chk("hold_busy_low", int'(busy), 0);
      repeat (4) @(negedge clk);
      #1;
      chk("result_held_found", int'(found), 1);
      chk("result_held_addr", int'(match_addr), 3);

      // reset while the FSM sits in COMPARE
      @(negedge clk); #1;
      word = "cow"; start_addr = 4'd0; end_addr = 4'd15; start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      chk("pre_reset_busy", int'(busy), 1);
      rst_n = 1'b0;
      @(negedge clk); #1;
      check_all_zero("midscan_reset");
      rst_n = 1'b1;
      run_scan("dog", 0, 15, 1'b0);

      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 9);
            mem[i] = (r == 0) ? 8'h00 : (8'h61 + 8'(r % 2));
         end
         if ($urandom_range(0, 1) == 1) begin
            b = $urandom_range(0, 13);
            k = {mem[b], mem[b+1], mem[b+2]};
         end else begin
            k = {8'h61 + 8'($urandom_range(0, 1)), 8'h61 + 8'($urandom_range(0, 1)),
                 8'h61 + 8'($urandom_range(0, 1))};
         end
         s = $urandom_range(0, 15);
         e = $urandom_range(0, 15);
         if ($urandom_range(0, 3) != 0 && e < s) e = 15;
         run_scan(k, s, e, 1'b0);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
